// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: in-order pipeline writeback versus queued
// long-latency results, with stale-entry invalidation, starvation stall and bypass.
module rf_write_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     pipe_wb_valid,
   input  logic [4:0]               pipe_wb_addr,
   input  logic [31:0]              pipe_wb_data,
   input  logic                     late_valid,
   input  logic [4:0]               late_addr,
   input  logic [31:0]              late_data,
   output logic                     late_ready,
   output logic                     reg_write_enable,
   output logic [4:0]               reg_write_addr,
   output logic [31:0]              reg_write_data,
   output logic                     stall_req,
   input  logic [4:0]               fwd_read_addr_1,
   input  logic [4:0]               fwd_read_addr_2,
   output logic                     fwd_hit_1,
   output logic                     fwd_hit_2,
   output logic [31:0]              fwd_data_1,
   output logic [31:0]              fwd_data_2,
   output logic                     fwd_pending_1,
   output logic                     fwd_pending_2,
   output logic [$clog2(DEPTH):0]   queue_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT) + 1;

   logic [DEPTH-1:0] q_valid_q, q_valid_d;
   logic [4:0]       q_addr_q [DEPTH];
   logic [4:0]       q_addr_d [DEPTH];
   logic [31:0]      q_data_q [DEPTH];
   logic [31:0]      q_data_d [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             stall_q, stall_d;
   logic             we_q, we_d;
   logic [4:0]       wa_q, wa_d;
   logic [31:0]      wd_q, wd_d;

   logic             q_empty_s, enq_s, pipe_ok_s, sel_queue_s;

   assign late_ready  = (count_q < CW'(DEPTH));
   assign q_empty_s   = (count_q == {CW{1'b0}});
   assign enq_s       = late_valid && late_ready && (late_addr != 5'd0);
   // A stall cycle hands the port to the queue; the pipe is held upstream.
   assign pipe_ok_s   = !stall_q && pipe_wb_valid && (pipe_wb_addr != 5'd0);
   assign sel_queue_s = !q_empty_s && (stall_q || !pipe_ok_s);

   // Source selection, queue update and next write-port value
   always_comb begin
      q_valid_d = q_valid_q;
      q_addr_d  = q_addr_q;
      q_data_d  = q_data_q;
      head_d    = head_q;
      tail_d    = tail_q;
      we_d      = 1'b0;
      wa_d      = 5'd0;
      wd_d      = 32'd0;
      if (pipe_ok_s) begin
         we_d = 1'b1;
         wa_d = pipe_wb_addr;
         wd_d = pipe_wb_data;
         // Older queued results to the same register are superseded by the pipe.
         for (int i = 0; i < DEPTH; i++) begin
            q_valid_d[i] = q_valid_q[i] && (q_addr_q[i] != pipe_wb_addr);
         end
      end else if (sel_queue_s) begin
         we_d              = q_valid_q[head_q];
         wa_d              = q_valid_q[head_q] ? q_addr_q[head_q] : 5'd0;
         wd_d              = q_valid_q[head_q] ? q_data_q[head_q] : 32'd0;
         q_valid_d[head_q] = 1'b0;
         head_d            = head_q + PW'(1);
      end else begin
         we_d = 1'b0;
      end
      if (enq_s) begin
         q_valid_d[tail_q] = 1'b1;
         q_addr_d[tail_q]  = late_addr;
         q_data_d[tail_q]  = late_data;
         tail_d            = tail_q + PW'(1);
      end else begin
         tail_d = tail_q;
      end
      count_d = count_q + CW'(enq_s) - CW'(sel_queue_s);
   end

   // Starvation counter and one-cycle stall request
   always_comb begin
      starve_d = {SW{1'b0}};
      stall_d  = 1'b0;
      if (q_empty_s || sel_queue_s) begin
         starve_d = {SW{1'b0}};
      end else if (starve_q == SW'(STARVE_LIMIT - 1)) begin
         stall_d  = 1'b1;
      end else begin
         starve_d = starve_q + SW'(1);
      end
   end

   // Pending lookup over live queue entries
   always_comb begin
      fwd_pending_1 = 1'b0;
      fwd_pending_2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_pending_1 = fwd_pending_1 | (q_valid_q[i] && (q_addr_q[i] == fwd_read_addr_1));
         fwd_pending_2 = fwd_pending_2 | (q_valid_q[i] && (q_addr_q[i] == fwd_read_addr_2));
      end
      fwd_pending_1 = fwd_pending_1 && (fwd_read_addr_1 != 5'd0);
      fwd_pending_2 = fwd_pending_2 && (fwd_read_addr_2 != 5'd0);
   end

   assign fwd_hit_1  = (fwd_read_addr_1 != 5'd0) && we_q && (wa_q == fwd_read_addr_1);
   assign fwd_hit_2  = (fwd_read_addr_2 != 5'd0) && we_q && (wa_q == fwd_read_addr_2);
   assign fwd_data_1 = fwd_hit_1 ? wd_q : 32'd0;
   assign fwd_data_2 = fwd_hit_2 ? wd_q : 32'd0;

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_valid_q <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            q_addr_q[i] <= 5'd0;
            q_data_q[i] <= 32'd0;
         end
         head_q   <= {PW{1'b0}};
         tail_q   <= {PW{1'b0}};
         count_q  <= {CW{1'b0}};
         starve_q <= {SW{1'b0}};
         stall_q  <= 1'b0;
         we_q     <= 1'b0;
         wa_q     <= 5'd0;
         wd_q     <= 32'd0;
      end else begin
         q_valid_q <= q_valid_d;
         q_addr_q  <= q_addr_d;
         q_data_q  <= q_data_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         starve_q  <= starve_d;
         stall_q   <= stall_d;
         we_q      <= we_d;
         wa_q      <= wa_d;
         wd_q      <= wd_d;
      end
   end

   assign reg_write_enable = we_q;
   assign reg_write_addr   = wa_q;
   assign reg_write_data   = wd_q;
   assign stall_req        = stall_q;
   assign queue_count      = count_q;

endmodule
